// File: rtl/pic_host_sequencer_pkg.sv
// Shared definitions for the interrupt-controller host sequencer: state
// encoding, ICW1 bit positions, A0 values and the write-list helper.
package pic_host_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SETUP  = 4'd1,
    ST_STROBE = 4'd2,
    ST_HOLD   = 4'd3,
    ST_ACK1   = 4'd4,
    ST_AGAP   = 4'd5,
    ST_ACK2   = 4'd6,
    ST_CAPT   = 4'd7,
    ST_RECOV  = 4'd8
  } state_e;

  // ICW1 bit positions that steer the write list.
  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;

  // A0 selects the command (ICW1) or data (ICW2..ICW4) register.
  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam logic [1:0] IDX_ICW1 = 2'd0;
  localparam logic [1:0] IDX_ICW2 = 2'd1;
  localparam logic [1:0] IDX_ICW3 = 2'd2;
  localparam logic [1:0] IDX_ICW4 = 2'd3;

  // Returns {last, next_idx}: last=1 means the word at idx was the final
  // write; otherwise next_idx is the following word, with ICW3 skipped in
  // single mode and ICW4 skipped when IC4 is clear.
  function automatic logic [2:0] next_icw(input logic [1:0] idx,
                                          input logic [7:0] icw1);
    logic [2:0] r;
    r = {1'b1, IDX_ICW1};
    case (idx)
      IDX_ICW1: r = {1'b0, IDX_ICW2};
      IDX_ICW2: begin
        if (!icw1[ICW1_SNGL])    r = {1'b0, IDX_ICW3};
        else if (icw1[ICW1_IC4]) r = {1'b0, IDX_ICW4};
        else                     r = {1'b1, IDX_ICW1};
      end
      IDX_ICW3: begin
        if (icw1[ICW1_IC4]) r = {1'b0, IDX_ICW4};
        else                r = {1'b1, IDX_ICW1};
      end
      default:  r = {1'b1, IDX_ICW1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_host_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module pic_host_sequencer_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side bus master for the interrupt controller: writes the ICW1..ICW4
// initialization list, then answers INT with a two-pulse INTA_n cycle and
// captures the vector byte.
//
// Host handshake: start is a request sampled only while the sequencer is
// idle and no request is already pending; the cycle it is sampled high
// latches icw1..icw4 and clears init_done. busy is the "not ready" signal:
// while busy=1 start is dropped. init_done high means the list was written;
// vector_valid is a one-cycle strobe qualifying a fresh vector.
module pic_host_sequencer
  import pic_host_sequencer_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       int_enable,
  input  logic       INT,
  input  logic [7:0] data_in,
  output logic       CS_n,
  output logic       WR_n,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       INTA_n,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] vector,
  output logic       vector_valid,
  output state_e     dbg_state
);

  localparam int unsigned CNT_MAX = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][7:0]  icw_q, icw_d;
  logic             start_q, start_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       vector_q, vector_d;
  logic             int_s;
  logic [2:0]       nxt;
  logic             wr_phase;

  pic_host_sequencer_sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (INT),
    .q_o   (int_s)
  );

  // State, timer, write index and latched host data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= IDX_ICW1;
      icw_q       <= '0;
      start_q     <= 1'b0;
      init_done_q <= 1'b0;
      vector_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      icw_q       <= icw_d;
      start_q     <= start_d;
      init_done_q <= init_done_d;
      vector_q    <= vector_d;
    end
  end

  // Next-state logic; the shared down-counter times every timed state and
  // a state is left on the cycle the counter reads zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    icw_d       = icw_q;
    start_d     = start_q;
    init_done_d = init_done_q;
    vector_d    = vector_q;
    nxt         = next_icw(idx_q, icw_q[0]);

    case (state_q)
      ST_IDLE: begin
        // A pending or newly arriving start outranks the interrupt path.
        if (start_q) begin
          start_d = 1'b0;
          idx_d   = IDX_ICW1;
          state_d = ST_SETUP;
        end else if (start) begin
          start_d     = 1'b1;
          icw_d       = {icw4, icw3, icw2, icw1};
          init_done_d = 1'b0;
        end else if (init_done_q && int_enable && int_s) begin
          cnt_d   = PW_LOAD;
          state_d = ST_ACK1;
        end
      end
      ST_SETUP: begin
        cnt_d   = PW_LOAD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (nxt[2]) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          idx_d   = nxt[1:0];
          state_d = ST_SETUP;
        end
      end
      ST_ACK1: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = ST_AGAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_AGAP: begin
        if (cnt_q == '0) begin
          cnt_d   = PW_LOAD;
          state_d = ST_ACK2;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK2: begin
        // The bus value on the last low cycle of the second pulse is the vector.
        if (cnt_q == '0) begin
          vector_d = data_in;
          state_d  = ST_CAPT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPT: begin
        cnt_d   = GAP_LOAD;
        state_d = ST_RECOV;
      end
      ST_RECOV: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the current state.
  always_comb begin
    wr_phase     = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                   (state_q == ST_HOLD);
    CS_n         = 1'b1;
    WR_n         = 1'b1;
    A0           = A0_CMD;
    data_out     = '0;
    data_oe      = 1'b0;
    INTA_n       = 1'b1;
    busy         = (state_q != ST_IDLE);
    init_done    = init_done_q;
    vector       = vector_q;
    vector_valid = (state_q == ST_CAPT);
    dbg_state    = state_q;
    if (wr_phase) begin
      CS_n     = 1'b0;
      data_oe  = 1'b1;
      A0       = (idx_q == IDX_ICW1) ? A0_CMD : A0_DATA;
      data_out = icw_q[idx_q];
      WR_n     = (state_q != ST_STROBE);
    end
    if ((state_q == ST_ACK1) || (state_q == ST_ACK2)) INTA_n = 1'b0;
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Self-checking bench for pic_host_sequencer (PULSE_W=2, GAP=2).
module tb_pic_host_sequencer;
  import pic_host_sequencer_pkg::*;

  localparam int PW = 2;
  localparam int GP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0;
  logic       int_enable = 1'b0;
  logic       INT = 1'b0;
  logic [7:0] data_in = '0;
  logic       CS_n, WR_n, A0, data_oe, INTA_n, busy, init_done, vector_valid;
  logic [7:0] data_out, vector;
  state_e     dbg_state;

  int tests = 0;
  int fails = 0;

  // Write records: {stable, low_len[7:0], a0, data[7:0]}.
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  pic_host_sequencer #(.PULSE_W(PW), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .int_enable(int_enable), .INT(INT), .data_in(data_in),
    .CS_n(CS_n), .WR_n(WR_n), .A0(A0), .data_out(data_out),
    .data_oe(data_oe), .INTA_n(INTA_n), .busy(busy),
    .init_done(init_done), .vector(vector), .vector_valid(vector_valid),
    .dbg_state(dbg_state)
  );

  // Clock
  initial forever #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Bus monitor: one record per WR_n pulse, checking setup/hold stability.
  initial begin : monitor
    logic       p_wr, p_cs, p_oe, p_a0, m_a0, m_stable;
    logic [7:0] p_data, m_data;
    int         m_len;
    p_wr = 1'b1; p_cs = 1'b1; p_oe = 1'b0; p_a0 = 1'b0; p_data = '0;
    m_a0 = 1'b0; m_data = '0; m_stable = 1'b0; m_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_wr = 1'b1; p_cs = 1'b1; p_oe = 1'b0; m_len = 0;
      end else begin
        if (p_wr && !WR_n) begin
          m_len    = 1;
          m_a0     = p_a0;
          m_data   = p_data;
          m_stable = !p_cs && p_oe && !CS_n && data_oe &&
                     (A0 == p_a0) && (data_out == p_data);
        end else if (!p_wr && !WR_n) begin
          m_len++;
          m_stable = m_stable && !CS_n && data_oe &&
                     (A0 == m_a0) && (data_out == m_data);
        end else if (!p_wr && WR_n) begin
          m_stable = m_stable && !CS_n && data_oe &&
                     (A0 == m_a0) && (data_out == m_data);
          obs_q.push_back({m_stable, 8'(m_len), m_a0, m_data});
        end
        p_wr = WR_n; p_cs = CS_n; p_oe = data_oe; p_a0 = A0; p_data = data_out;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference write list from the ICW1 rules.
  task automatic build_exp(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'(PW), 1'b0, a});
    exp_q.push_back({1'b1, 8'(PW), 1'b1, b});
    if (!a[1]) exp_q.push_back({1'b1, 8'(PW), 1'b1, c});
    if (a[0])  exp_q.push_back({1'b1, 8'(PW), 1'b1, d});
  endtask

  task automatic check_writes();
    logic [17:0] o, e;
    check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("write", 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_init(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    int rise;
    int n;
    build_exp(a, b, c, d);
    n = exp_q.size();
    step();
    icw1 = a; icw2 = b; icw3 = c; icw4 = d;
    obs_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check("init_cleared", 32'(init_done), 32'(0));
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (init_done) begin
        rise = k;
        break;
      end
    end
    check("init_rise", 32'(rise), 32'(n * (PW + 2) + 1));
    check_writes();
  endtask

  // INT raised at k=0; INT dropped at drop_k; vector appears on the bus
  // only during the last low cycle of the second pulse.
  task automatic run_ack(input int drop_k, input logic [7:0] val);
    int  f;
    int  vv_k;
    logic ei;
    f    = 3;
    vv_k = f + 2 * PW + GP;
    step();
    data_in = ~val;
    INT     = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      ei = !(((k >= f) && (k < f + PW)) ||
             ((k >= f + PW + GP) && (k < f + 2 * PW + GP)));
      check("inta_n", 32'(INTA_n), 32'(ei));
      check("vector_valid", 32'(vector_valid), 32'(k == vv_k));
      if (k == vv_k) check("vector", 32'(vector), 32'(val));
      if (k == vv_k - 1) data_in = val;
      if (k == drop_k) INT = 1'b0;
    end
    INT = 1'b0;
    check("vector_hold", 32'(vector), 32'(val));
  endtask

  initial begin : main
    logic all_high;
    int   rise, fall, vvk;
    logic hit;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_cs_n", 32'(CS_n), 32'(1));
    check("rst_wr_n", 32'(WR_n), 32'(1));
    check("rst_inta_n", 32'(INTA_n), 32'(1));
    check("rst_a0", 32'(A0), 32'(0));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_data_oe", 32'(data_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_init_done", 32'(init_done), 32'(0));
    check("rst_vector", 32'(vector), 32'(0));
    check("rst_vector_valid", 32'(vector_valid), 32'(0));
    rst_n = 1'b1;
    step();

    // INT before initialization is ignored
    int_enable = 1'b1;
    INT = 1'b1;
    all_high = 1'b1;
    repeat (10) begin
      step();
      all_high = all_high & INTA_n;
    end
    check("gate_before_init", 32'(all_high), 32'(1));
    INT = 1'b0;
    repeat (3) step();

    // Directed write lists
    do_init(8'h12, 8'h40, 8'hAA, 8'h55);
    do_init(8'h13, 8'h48, 8'hAA, 8'h01);
    do_init(8'h11, 8'h20, 8'h04, 8'h03);

    // Acknowledge: full INT, then INT dropped right after ACK1
    run_ack(9, 8'h43);
    run_ack(5, 8'h81);

    // int_enable=0 blocks acknowledge
    int_enable = 1'b0;
    INT = 1'b1;
    all_high = 1'b1;
    repeat (10) begin
      step();
      all_high = all_high & INTA_n;
    end
    check("gate_int_disabled", 32'(all_high), 32'(1));
    INT = 1'b0;
    repeat (3) step();
    int_enable = 1'b1;

    // start together with a synchronized INT: writes first, then acknowledge
    step();
    INT = 1'b1;
    data_in = 8'hC3;
    step();
    step();
    icw1 = 8'h12; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h00;
    build_exp(8'h12, 8'h40, 8'h00, 8'h00);
    obs_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    rise = -1; fall = -1; vvk = -1;
    for (int k = 4; k <= 80; k++) begin
      step();
      if (init_done && rise < 0) rise = k;
      if (!INTA_n && fall < 0) fall = k;
      if (vector_valid && vvk < 0) begin
        vvk = k;
        INT = 1'b0;
      end
      if (vvk > 0 && k > vvk + 6) break;
    end
    INT = 1'b0;
    check("si_init_rise", 32'(rise), 32'(3 + 2 * (PW + 2) + 1));
    check("si_ack_after_init", 32'((rise > 0) && (fall > rise)), 32'(1));
    check("si_ack_len", 32'(vvk - fall), 32'(2 * PW + GP));
    check("si_vector", 32'(vector), 32'(8'hC3));
    check_writes();

    // Randomized write lists and acknowledges
    for (int i = 0; i < 6; i++) begin
      do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_ack(int'($urandom_range(5, 9)), 8'($urandom));
    end
    run_ack(9, 8'h5A);

    // Reset in the middle of a strobe
    step();
    icw1 = 8'h11; icw2 = 8'h22; icw3 = 8'h33; icw4 = 8'h44;
    start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!WR_n) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reach_strobe", 32'(hit), 32'(1));
    rst_n = 1'b0;
    step();
    check("mid_rst_wr_n", 32'(WR_n), 32'(1));
    check("mid_rst_cs_n", 32'(CS_n), 32'(1));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_init_done", 32'(init_done), 32'(0));
    check("mid_rst_vector", 32'(vector), 32'(0));
    check("mid_rst_data_oe", 32'(data_oe), 32'(0));
    rst_n = 1'b1;
    step();

    // Recovery after reset
    do_init(8'h13, 8'h48, 8'h00, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
